// File: rtl/idct_8x8_serial.sv
// Serial 8x8 inverse DCT: buffers one 64-coefficient block, then produces each
// pixel with a 64-cycle MAC against a combinational separable basis.
//
// state | meaning
// LOAD  | accepting coefficients into the buffer, raster index widx
// MAC   | accumulating 64 basis terms for pixel p, one per cycle
// EMIT  | presenting pixel p until the downstream accepts it
module idct_8x8_serial #(
  parameter int COEF_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic              pix_last,
  output logic              busy
);

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(512);
  localparam logic signed [ACC_W-1:0] OFS = ACC_W'(128);

  state_t state_q, state_d;
  logic [5:0] widx_q, kidx_q, p_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [COEF_W-1:0] coef_buf [64];

  logic coef_xfer, pix_xfer;
  logic signed [12:0] c1, c2;
  logic signed [25:0] cc;
  logic signed [15:0] bv;
  logic signed [COEF_W-1:0] xv;
  logic signed [COEF_W+15:0] prod;
  logic signed [ACC_W-1:0] term, sum, scaled, pixv;
  logic [7:0] pix_sat;

  // 4096*a(k)*cos(m*pi/16) folded onto the first quadrant; m = (2n+1)k mod 32.
  function automatic logic signed [12:0] cbasis(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] r;
    logic [4:0] idx;
    logic signed [12:0] mag;
    r = {1'b0, n, 1'b1} * {2'b00, k};
    if (r > 5'd16) r = 5'd0 - r;
    idx = (r > 5'd8) ? (5'd16 - r) : r;
    case (idx)
      5'd0:    mag = 13'sd2048;
      5'd1:    mag = 13'sd2009;
      5'd2:    mag = 13'sd1892;
      5'd3:    mag = 13'sd1703;
      5'd4:    mag = 13'sd1448;
      5'd5:    mag = 13'sd1138;
      5'd6:    mag = 13'sd784;
      5'd7:    mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    if (k == 3'd0) return 13'sd1448;
    else if (r > 5'd8) return -mag;
    else return mag;
  endfunction

  assign coef_ready = (state_q == LOAD);
  assign pix_valid  = (state_q == EMIT);
  assign busy       = !((state_q == LOAD) && (widx_q == 6'd0));
  assign coef_xfer  = coef_valid && coef_ready;
  assign pix_xfer   = pix_valid && pix_ready;

  always_comb begin
    c1     = cbasis(kidx_q[5:3], p_q[5:3]);
    c2     = cbasis(kidx_q[2:0], p_q[2:0]);
    cc     = c1 * c2 + 26'sd8192;
    bv     = 16'(cc >>> 14);
    xv     = $signed(coef_buf[kidx_q]);
    prod   = xv * bv;
    term   = ACC_W'(prod);
    sum    = acc_q + term;
    scaled = (sum + RND) >>> 10;
    pixv   = scaled + OFS;
    if (pixv[ACC_W-1])          pix_sat = 8'd0;
    else if (|pixv[ACC_W-2:8])  pix_sat = 8'd255;
    else                        pix_sat = pixv[7:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (coef_xfer && widx_q == 6'd63) state_d = MAC;
      MAC:  if (kidx_q == 6'd63) state_d = EMIT;
      EMIT: if (pix_xfer) state_d = (p_q == 6'd63) ? LOAD : MAC;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Buffer is not reset; a fresh block always overwrites all 64 entries.
  always_ff @(posedge clk) begin
    if (coef_xfer) coef_buf[widx_q] <= coef_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx_q   <= 6'd0;
      kidx_q   <= 6'd0;
      p_q      <= 6'd0;
      acc_q    <= '0;
      pix_data <= 8'd0;
      pix_last <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          kidx_q <= 6'd0;
          acc_q  <= '0;
          p_q    <= 6'd0;
          if (coef_xfer) widx_q <= widx_q + 6'd1;
        end
        MAC: begin
          acc_q  <= sum;
          kidx_q <= kidx_q + 6'd1;
          if (kidx_q == 6'd63) begin
            pix_data <= pix_sat;
            pix_last <= (p_q == 6'd63);
          end
        end
        EMIT: begin
          kidx_q <= 6'd0;
          acc_q  <= '0;
          if (pix_xfer) begin
            pix_last <= 1'b0;
            p_q      <= p_q + 6'd1;
            widx_q   <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/idct_8x8_serial.md
IDCT_8X8_SERIAL -- requirements
Module: idct_8x8_serial

Interface
REQ-001 The block SHALL have parameter COEF_W, default 16, meaning signed coefficient input width.
REQ-002 The block SHALL have parameter ACC_W, default 36, meaning signed MAC accumulator width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port coef_valid, input, 1, coefficient word valid.
REQ-006 The block SHALL have port coef_ready, output, 1, block accepts a coefficient this cycle.
REQ-007 The block SHALL have port coef_data, input, COEF_W, signed DCT coefficient X(k1,k2), raster order k1*8+k2.
REQ-008 The block SHALL have port pix_valid, output, 1, pixel word valid.
REQ-009 The block SHALL have port pix_ready, input, 1, downstream accepts the pixel.
REQ-010 The block SHALL have port pix_data, output, 8, unsigned reconstructed pixel x(n1,n2), raster order n1*8+n2.
REQ-011 The block SHALL have port pix_last, output, 1, high with pixel index 63 only.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than LOAD with zero coefficients held.

Function
REQ-013 The handshakes SHALL be: a transfer occurs on a cycle where valid and ready are both high.
REQ-014 The FSM SHALL have states LOAD, MAC and EMIT.
REQ-015 In LOAD, coef_ready SHALL be 1 and each transfer SHALL write coef_data to buffer index 0..63.
REQ-016 The transfer at index 63 SHALL move LOAD to MAC with pixel index p=0.
REQ-017 MAC SHALL last exactly 64 cycles, adding one term X(k1,k2)*B(k1,k2,n1,n2) per cycle for k=0..63, accumulator cleared at entry.
REQ-018 The block SHALL define the 1D basis as C[k][n] = round(4096*a(k)*cos((2n+1)k*pi/16)), 13-bit signed, with a(0)=sqrt(1/8) and a(k>0)=1/2.
REQ-019 The block SHALL define B as (C[k1][n1]*C[k2][n2] + 8192) >>> 14, arithmetic shift.
REQ-020 After the 64th term, the block SHALL compute pixel = ((acc + 512) >>> 10) + 128, saturated to 0..255, and enter EMIT.
REQ-021 In EMIT, pix_valid SHALL be 1.
REQ-022 While pix_valid=1 and pix_ready=0, pix_data and pix_last SHALL hold stable.
REQ-023 On a pixel transfer with p<63, the FSM SHALL go to MAC with p+1.
REQ-024 On a pixel transfer with p=63, the FSM SHALL go to LOAD with write index 0.
REQ-025 Latency SHALL be: the first pix_valid is asserted on the 65th cycle after the cycle of the 64th coefficient transfer.
REQ-026 Each subsequent pixel SHALL be presented 65 cycles after the previous pixel transfer.
REQ-027 coef_ready SHALL be 0 in MAC and EMIT, so coefficient and pixel transfers never coincide.
REQ-028 The accumulator SHALL be ACC_W bits; no overflow occurs for any COEF_W=16 input.
REQ-029 Saturation SHALL apply only at the final 8-bit conversion.

Reset
REQ-030 On rst_n low, the block SHALL immediately force state LOAD, write index 0, p=0, accumulator 0, coef_ready=1, pix_valid=0, pix_data=0, pix_last=0 and busy=0.
REQ-031 A reset mid-LOAD, mid-MAC or mid-EMIT SHALL discard the partial block; the buffer contents are don't-care.
REQ-032 After reset release, the first accepted coefficient SHALL be index 0.

Verification
REQ-033 The bench SHALL cover the all-zero block: 64 zeros -> 64 pixels of 128, pix_last on the 64th only.
REQ-034 The bench SHALL cover DC only: X(0,0)=80, rest 0 -> all 64 pixels = 138 (B=128 for k1=k2=0).
REQ-035 The bench SHALL cover saturation: X(0,0)=2000 -> all pixels 255; X(0,0)=-2000 -> all pixels 0.
REQ-036 The bench SHALL cover a random block against a bit-exact golden model of REQ-018..020, with pix_ready toggled randomly -> pix_data is stable while stalled, order is raster, and pixel spacing is 65 cycles when unstalled.
REQ-037 The bench SHALL cover reset during MAC at p=10: rst_n pulsed low -> outputs reach reset values without waiting for a clock edge; a new block then decodes correctly.
REQ-038 The bench SHALL cover back-to-back blocks: a second block is presented while EMIT is at p=63 -> coef_ready stays 0 until the pix_last transfer, then returns to 1 on the next cycle.
